// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, ASCII control codes and parity helper for the
// PS/2 keyboard decoder.
package keyboard_pkg;

  // Scan-code set 2 prefixes and modifier keys
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // ASCII control characters produced by non-printing keys
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;

  // Odd parity over parity bit plus data: a good byte has an odd number of ones
  function automatic logic parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/scan2ascii.sv
// Combinational scan-code-set-2 to ASCII lookup. Letters honour Shift XOR Caps,
// digits and punctuation honour Shift only, control keys ignore both.
module scan2ascii
  import keyboard_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_char,
  output logic       o_mapped
);

  logic [7:0] w_base;
  logic       w_letter;

  // Table lookup: lowercase/unshifted base character plus letter flag
  always_comb begin
    w_base   = 8'h00;
    w_letter = 1'b0;
    o_mapped = 1'b1;
    case (i_code)
      8'h1C: begin w_base = 8'h61; w_letter = 1'b1; end
      8'h32: begin w_base = 8'h62; w_letter = 1'b1; end
      8'h21: begin w_base = 8'h63; w_letter = 1'b1; end
      8'h23: begin w_base = 8'h64; w_letter = 1'b1; end
      8'h24: begin w_base = 8'h65; w_letter = 1'b1; end
      8'h2B: begin w_base = 8'h66; w_letter = 1'b1; end
      8'h34: begin w_base = 8'h67; w_letter = 1'b1; end
      8'h33: begin w_base = 8'h68; w_letter = 1'b1; end
      8'h43: begin w_base = 8'h69; w_letter = 1'b1; end
      8'h3B: begin w_base = 8'h6A; w_letter = 1'b1; end
      8'h42: begin w_base = 8'h6B; w_letter = 1'b1; end
      8'h4B: begin w_base = 8'h6C; w_letter = 1'b1; end
      8'h3A: begin w_base = 8'h6D; w_letter = 1'b1; end
      8'h31: begin w_base = 8'h6E; w_letter = 1'b1; end
      8'h44: begin w_base = 8'h6F; w_letter = 1'b1; end
      8'h4D: begin w_base = 8'h70; w_letter = 1'b1; end
      8'h15: begin w_base = 8'h71; w_letter = 1'b1; end
      8'h2D: begin w_base = 8'h72; w_letter = 1'b1; end
      8'h1B: begin w_base = 8'h73; w_letter = 1'b1; end
      8'h2C: begin w_base = 8'h74; w_letter = 1'b1; end
      8'h3C: begin w_base = 8'h75; w_letter = 1'b1; end
      8'h2A: begin w_base = 8'h76; w_letter = 1'b1; end
      8'h1D: begin w_base = 8'h77; w_letter = 1'b1; end
      8'h22: begin w_base = 8'h78; w_letter = 1'b1; end
      8'h35: begin w_base = 8'h79; w_letter = 1'b1; end
      8'h1A: begin w_base = 8'h7A; w_letter = 1'b1; end
      8'h45: w_base = i_shift ? 8'h29 : 8'h30;
      8'h16: w_base = i_shift ? 8'h21 : 8'h31;
      8'h1E: w_base = i_shift ? 8'h40 : 8'h32;
      8'h26: w_base = i_shift ? 8'h23 : 8'h33;
      8'h25: w_base = i_shift ? 8'h24 : 8'h34;
      8'h2E: w_base = i_shift ? 8'h25 : 8'h35;
      8'h36: w_base = i_shift ? 8'h5E : 8'h36;
      8'h3D: w_base = i_shift ? 8'h26 : 8'h37;
      8'h3E: w_base = i_shift ? 8'h2A : 8'h38;
      8'h46: w_base = i_shift ? 8'h28 : 8'h39;
      8'h4E: w_base = i_shift ? 8'h5F : 8'h2D;
      8'h55: w_base = i_shift ? 8'h2B : 8'h3D;
      8'h41: w_base = i_shift ? 8'h3C : 8'h2C;
      8'h49: w_base = i_shift ? 8'h3E : 8'h2E;
      8'h4A: w_base = i_shift ? 8'h3F : 8'h2F;
      8'h29: w_base = ASCII_SPACE;
      8'h5A: w_base = ASCII_CR;
      8'h66: w_base = ASCII_BS;
      8'h0D: w_base = ASCII_TAB;
      8'h76: w_base = ASCII_ESC;
      default: o_mapped = 1'b0;
    endcase
  end

  // Letters become uppercase when exactly one of Shift / Caps Lock is active
  always_comb begin
    if (w_letter && (i_shift ^ i_caps)) begin
      o_char = w_base & 8'hDF;
    end else begin
      o_char = w_base;
    end
  end

endmodule

// File: rtl/keyboard_controller.sv
// PS/2 scan-code-set-2 byte stream to ASCII decoder: parity check, prefix and
// modifier tracking, registered character/strobe outputs.
module keyboard_controller
  import keyboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] scan_code_p,
  input  logic       valid,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic       parity_err
);

  logic [7:0] r_ascii;
  logic       r_ascii_valid;
  logic       r_parity_err;
  logic       r_break_pend;
  logic       r_ext_pend;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;

  logic [7:0] w_code;
  logic       w_parity_ok;
  logic [7:0] w_char;
  logic       w_mapped;

  assign w_code      = scan_code_p[7:0];
  assign w_parity_ok = parity_ok(scan_code_p);

  scan2ascii u_scan2ascii (
    .i_code   (w_code),
    .i_shift  (r_lshift | r_rshift),
    .i_caps   (r_caps),
    .o_char   (w_char),
    .o_mapped (w_mapped)
  );

  // Per-byte decode: parity, prefix/modifier flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ascii       <= 8'h00;
      r_ascii_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      r_break_pend  <= 1'b0;
      r_ext_pend    <= 1'b0;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps        <= 1'b0;
    end else begin
      r_ascii_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      if (valid) begin
        if (!w_parity_ok) begin
          // A corrupted byte could have been part of a prefix sequence
          r_parity_err <= 1'b1;
          r_break_pend <= 1'b0;
          r_ext_pend   <= 1'b0;
        end else begin
          case (w_code)
            SC_EXT:   r_ext_pend   <= 1'b1;
            SC_BREAK: r_break_pend <= 1'b1;
            default: begin
              r_break_pend <= 1'b0;
              r_ext_pend   <= 1'b0;
              if (w_code == SC_LSHIFT) begin
                r_lshift <= ~r_break_pend;
              end else if (w_code == SC_RSHIFT) begin
                r_rshift <= ~r_break_pend;
              end else if (w_code == SC_CAPS) begin
                if (!r_break_pend) begin
                  r_caps <= ~r_caps;
                end else begin
                  r_caps <= r_caps;
                end
              end else if (!r_break_pend && !r_ext_pend && w_mapped) begin
                r_ascii       <= w_char;
                r_ascii_valid <= 1'b1;
              end else begin
                r_ascii <= r_ascii;
              end
            end
          endcase
        end
      end else begin
        r_ascii <= r_ascii;
      end
    end
  end

  assign ascii       = r_ascii;
  assign ascii_valid = r_ascii_valid;
  assign parity_err  = r_parity_err;

endmodule

// File: tb/tb_keyboard_controller.sv
// Self-checking bench for keyboard_controller: table-driven byte stream with a
// scoreboard of expected outputs, plus hand-written reset sequences.
module tb_keyboard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] scan_code_p;
  logic       valid;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyboard_controller dut (
    .clk         (clk),
    .rst         (rst),
    .scan_code_p (scan_code_p),
    .valid       (valid),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic [7:0] code;
    logic       vld;
    logic       bad;
    logic       ev;
    logic [7:0] ea;
    logic       ep;
  } vec_t;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic       p;
  } exp_t;

  vec_t       tbl[$];
  exp_t       sb[$];
  logic [7:0] hold;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Good byte with its expected character (ev=0 means no strobe)
  task automatic add(input logic [7:0] code, input logic ev, input logic [7:0] ea);
    vec_t t;
    t.code = code; t.vld = 1'b1; t.bad = 1'b0; t.ev = ev; t.ea = ea; t.ep = 1'b0;
    tbl.push_back(t);
  endtask

  task automatic add_bad(input logic [7:0] code);
    vec_t t;
    t.code = code; t.vld = 1'b1; t.bad = 1'b1; t.ev = 1'b0; t.ea = 8'h00; t.ep = 1'b1;
    tbl.push_back(t);
  endtask

  task automatic add_idle(input logic [7:0] code);
    vec_t t;
    t.code = code; t.vld = 1'b0; t.bad = 1'b0; t.ev = 1'b0; t.ea = 8'h00; t.ep = 1'b0;
    tbl.push_back(t);
  endtask

  // Drive one entry (called at a falling edge) and record what must follow
  task automatic drive(input vec_t t);
    exp_t e;
    scan_code_p = t.bad ? {^t.code, t.code} : {~^t.code, t.code};
    valid       = t.vld;
    if (t.ev) hold = t.ea;
    e.v = t.ev; e.a = hold; e.p = t.ep;
    sb.push_back(e);
  endtask

  // One edge later the registered outputs reflect the driven byte
  task automatic collect(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {7'd0, ascii_valid}, {7'd0, e.v});
      chk({tag, "_perr"},  {7'd0, parity_err},  {7'd0, e.p});
      chk({tag, "_ascii"}, ascii, e.a);
    end
  endtask

  task automatic run_one(input logic [7:0] code, input logic ev, input logic [7:0] ea, input string tag);
    vec_t t;
    t.code = code; t.vld = 1'b1; t.bad = 1'b0; t.ev = ev; t.ea = ea; t.ep = 1'b0;
    drive(t);
    collect(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ascii"}, ascii, 8'h00);
    chk({tag, "_valid"}, {7'd0, ascii_valid}, 8'h00);
    chk({tag, "_perr"},  {7'd0, parity_err},  8'h00);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; scan_code_p = 9'h000; hold = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic make / break
    add(8'h1C, 1'b1, 8'h61);
    add(8'hF0, 1'b0, 8'h00); add(8'h1C, 1'b0, 8'h00);
    add(8'h32, 1'b1, 8'h62);
    // Left shift press, release
    add(8'h12, 1'b0, 8'h00); add(8'h1C, 1'b1, 8'h41);
    add(8'hF0, 1'b0, 8'h00); add(8'h12, 1'b0, 8'h00);
    add(8'h1C, 1'b1, 8'h61);
    // Caps + right shift cancel on letters, digits see shift only
    add(8'h58, 1'b0, 8'h00); add(8'h59, 1'b0, 8'h00);
    add(8'h1C, 1'b1, 8'h61); add(8'h16, 1'b1, 8'h21);
    add(8'hF0, 1'b0, 8'h00); add(8'h59, 1'b0, 8'h00);
    add(8'h1C, 1'b1, 8'h41); add(8'h16, 1'b1, 8'h31);
    // Caps toggles on make only
    add(8'h58, 1'b0, 8'h00); add(8'hF0, 1'b0, 8'h00); add(8'h58, 1'b0, 8'h00);
    add(8'h1C, 1'b1, 8'h61);
    // Parity errors drop the byte and clear a pending break
    add_bad(8'h1C);
    add(8'hF0, 1'b0, 8'h00); add_bad(8'h1C);
    add(8'h32, 1'b1, 8'h62);
    add(8'hF0, 1'b0, 8'h00); add(8'h32, 1'b0, 8'h00); add(8'h1C, 1'b1, 8'h61);
    // Extended and unmapped codes
    add(8'hE0, 1'b0, 8'h00); add(8'h75, 1'b0, 8'h00);
    add(8'hE0, 1'b0, 8'h00); add(8'hF0, 1'b0, 8'h00); add(8'h75, 1'b0, 8'h00);
    add(8'h05, 1'b0, 8'h00);
    add(8'hE0, 1'b0, 8'h00); add(8'h1C, 1'b0, 8'h00); add(8'h2D, 1'b1, 8'h72);
    // Idle cycles ignore the bus contents
    add_idle(8'h1C); add_idle(8'hF0);
    // Control keys and punctuation
    add(8'h29, 1'b1, 8'h20); add(8'h5A, 1'b1, 8'h0D); add(8'h66, 1'b1, 8'h08);
    add(8'h0D, 1'b1, 8'h09); add(8'h76, 1'b1, 8'h1B); add(8'h4E, 1'b1, 8'h2D);
    add(8'h12, 1'b0, 8'h00);
    add(8'h4E, 1'b1, 8'h5F); add(8'h4A, 1'b1, 8'h3F); add(8'h45, 1'b1, 8'h29);
    add(8'h3E, 1'b1, 8'h2A); add(8'h36, 1'b1, 8'h5E); add(8'h29, 1'b1, 8'h20);
    add(8'h1A, 1'b1, 8'h5A);
    add(8'hF0, 1'b0, 8'h00); add(8'h12, 1'b0, 8'h00);
    add(8'h49, 1'b1, 8'h2E); add(8'h55, 1'b1, 8'h3D); add(8'h46, 1'b1, 8'h39);
    add(8'h41, 1'b1, 8'h2C); add(8'h35, 1'b1, 8'h79);

    // Back-to-back application of the table
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      collect($sformatf("vec%0d", i));
    end
    valid = 1'b0;

    // Reset after Shift make and a lone break prefix discards both
    run_one(8'h12, 1'b0, 8'h00, "pre_shift");
    run_one(8'hF0, 1'b0, 8'h00, "pre_brk");
    rst = 1'b1;
    scan_code_p = {~^8'h1C, 8'h1C};
    valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_prio0");
    @(negedge clk);
    check_reset_outputs("rst_prio1");
    rst = 1'b0; valid = 1'b0; hold = 8'h00;
    run_one(8'h1C, 1'b1, 8'h61, "post_rst");
    valid = 1'b0;
    collect_idle: begin
      @(negedge clk);
      chk("post_rst_idle", {7'd0, ascii_valid}, 8'h00);
      chk("post_rst_hold", ascii, 8'h61);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
